// File: rtl/frequency_meter_pkg.sv
// frequency_meter_pkg
//   Shared constants and types for the frequency meter: millisecond cycle
//   count at the default clock, gate-select encodings, the per-gate scale
//   table that turns an edge count into Hz, and the FSM state encoding.
package frequency_meter_pkg;

  // Cycles per millisecond at the default 100 MHz system clock.
  localparam int unsigned CYCLES_PER_MS = 100_000;

  typedef enum logic [1:0] {
    GATE_1MS   = 2'b00,
    GATE_10MS  = 2'b01,
    GATE_100MS = 2'b10,
    GATE_1S    = 2'b11
  } gate_sel_e;

  // Multiplier that converts an edge count over the gate into Hz,
  // indexed by gate_sel_e: [0]=1000 (1 ms) ... [3]=1 (1 s).
  localparam logic [3:0][9:0] SCALE_TBL = {10'd1, 10'd10, 10'd100, 10'd1000};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GATE  = 2'd1,
    ST_SCALE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Gate length in system clock cycles for a given cycles-per-ms rate.
  function automatic logic [26:0] gate_cycles(input int unsigned cpm,
                                              input gate_sel_e   sel);
    int unsigned n;
    case (sel)
      GATE_1MS:   n = cpm;
      GATE_10MS:  n = cpm * 10;
      GATE_100MS: n = cpm * 100;
      default:    n = cpm * 1000;
    endcase
    return n[26:0];
  endfunction

endpackage

// File: rtl/frequency_meter_edge_sync.sv
// edge_sync
//   Brings an asynchronous input into the clk domain through two flops and
//   flags a rising edge using one extra history flop.
//   Ports: clk, rst_n (async active-low), d (async input),
//          rise (one-cycle pulse when the synchronized input goes 0->1).
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= d;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign rise = r_sync2 & ~r_hist;

endmodule

// File: rtl/frequency_meter.sv
// frequency_meter
//   Gated-count frequency meter. Counts rising edges of sig_in over a gate
//   of 1 ms / 10 ms / 100 ms / 1 s, scales the count to Hz, saturates at
//   F_MAX, and tracks min/max results.
//   Ports:
//     clk, rst_n       system clock, async active-low reset
//     sig_in           asynchronous signal to measure
//     start            one-cycle request to begin (ignored while busy)
//     continuous       re-arm automatically after each result
//     gate_sel         gate length select (latched at gate start)
//     clear_extrema    reset min/max trackers
//     busy             FSM not idle
//     meas_freq        last result in Hz, meas_valid pulses on update
//     overflow         last result saturated at F_MAX
//     min_freq/max_freq extrema since last clear
module frequency_meter
  import frequency_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned F_MAX  = 999_999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sig_in,
  input  logic        start,
  input  logic        continuous,
  input  logic [1:0]  gate_sel,
  input  logic        clear_extrema,
  output logic        busy,
  output logic [19:0] meas_freq,
  output logic        meas_valid,
  output logic        overflow,
  output logic [19:0] min_freq,
  output logic [19:0] max_freq
);

  localparam int unsigned CPM = CLK_HZ / 1000;

  state_e      r_state;
  gate_sel_e   r_sel;
  logic [26:0] r_gcnt;
  logic [19:0] r_cnt;
  logic [19:0] r_res;
  logic        r_ovf;
  logic [19:0] r_freq;
  logic        r_valid;
  logic        r_ovf_out;
  logic [19:0] r_min;
  logic [19:0] r_max;

  logic        w_rise;
  logic [26:0] w_glen;
  logic [29:0] w_prod;

  edge_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sig_in),
    .rise (w_rise)
  );

  assign w_glen = gate_cycles(CPM, r_sel);
  // Full 30-bit product so saturation is judged on the untruncated value.
  assign w_prod = {10'd0, r_cnt} * {20'd0, SCALE_TBL[r_sel]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sel     <= GATE_1MS;
      r_gcnt    <= '0;
      r_cnt     <= '0;
      r_res     <= '0;
      r_ovf     <= 1'b0;
      r_freq    <= '0;
      r_valid   <= 1'b0;
      r_ovf_out <= 1'b0;
      r_min     <= '1;
      r_max     <= '0;
    end else begin
      r_valid <= 1'b0;
      if (clear_extrema) begin
        r_min <= '1;
        r_max <= '0;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sel   <= gate_sel_e'(gate_sel);
            r_gcnt  <= '0;
            r_cnt   <= '0;
            r_state <= ST_GATE;
          end
        end
        ST_GATE: begin
          r_gcnt <= r_gcnt + 27'd1;
          // Edge on the final gate cycle still lands here before leaving.
          if (w_rise && (r_cnt != '1)) r_cnt <= r_cnt + 20'd1;
          if (r_gcnt == w_glen - 27'd1) r_state <= ST_SCALE;
        end
        ST_SCALE: begin
          if (w_prod > 30'(F_MAX)) begin
            r_res <= 20'(F_MAX);
            r_ovf <= 1'b1;
          end else begin
            r_res <= w_prod[19:0];
            r_ovf <= 1'b0;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_freq    <= r_res;
          r_ovf_out <= r_ovf;
          r_valid   <= 1'b1;
          // A same-cycle clear wins first, so the result seeds both trackers.
          if (clear_extrema || (r_res < r_min)) r_min <= r_res;
          if (clear_extrema || (r_res > r_max)) r_max <= r_res;
          if (continuous) begin
            r_sel   <= gate_sel_e'(gate_sel);
            r_gcnt  <= '0;
            r_cnt   <= '0;
            r_state <= ST_GATE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign meas_freq  = r_freq;
  assign meas_valid = r_valid;
  assign overflow   = r_ovf_out;
  assign min_freq   = r_min;
  assign max_freq   = r_max;

endmodule
